// File: rtl/bp_update_sequencer.sv
// -----------------------------------------------------------------------------
// bp_update_sequencer
//
// Walks a bank of N_WEIGHTS 32-bit weights. For each weight it reads the value
// from the weight store, shows it to the shared combinational update datapath,
// and writes the datapath result back. The update operands (bp, tm, td) are
// latched once per pass, so a single datapath instance serves the whole bank.
//
// Each weight takes three cycles: RD (address out), LAT (capture read data),
// WR (write datapath result). A DONE cycle closes the pass.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               request one pass; only sampled in IDLE
//   abort               cancel the pass in progress (RD/LAT/WR only)
//   bp, tm, td          update operands, latched on an accepted start
//   w_addr              weight store address
//   w_rdata             weight store read data, valid 1 cycle after w_addr
//   w_we, w_wdata       weight store write enable / write data
//   dp_w, dp_bp,
//   dp_tm, dp_td        operands to the external update datapath
//   dp_wn               combinational result from the update datapath
//   busy                pass in progress (RD, LAT, WR, DONE)
//   done                one-cycle pulse while in DONE
//   err                 one-cycle pulse when start is rejected (td == 0)
//   pass_cnt            completed passes, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module bp_update_sequencer #(
   parameter int N_WEIGHTS = 8,
   parameter int ADDR_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [31:0]       bp,
   input  logic [31:0]       tm,
   input  logic [31:0]       td,
   output logic [ADDR_W-1:0] w_addr,
   input  logic [31:0]       w_rdata,
   output logic              w_we,
   output logic [31:0]       w_wdata,
   output logic [31:0]       dp_w,
   output logic [31:0]       dp_bp,
   output logic [31:0]       dp_tm,
   output logic [31:0]       dp_td,
   input  logic [31:0]       dp_wn,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       pass_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      LAT,
      WR,
      DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WEIGHTS - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;

   // The store address simply follows the weight index; it is meaningful in
   // RD (read request) and WR (write target).
   assign w_addr = idx;

   // Write strobe and data are decoded from state rather than registered so
   // that abort can suppress the write in the very cycle it is raised.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_we    = 1'b0;
      w_wdata = '0;
      if (state == WR) begin
         w_we    = ~abort;
         w_wdata = dp_wn;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         dp_w     <= '0;
         dp_bp    <= '0;
         dp_tm    <= '0;
         dp_td    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         pass_cnt <= '0;
      end else begin
         // Pulses default low and are raised only on the cycle they apply.
         err  <= 1'b0;
         done <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  if (td != '0) begin
                     dp_bp <= bp;
                     dp_tm <= tm;
                     dp_td <= td;
                     idx   <= '0;
                     busy  <= 1'b1;
                     state <= RD;
                  end else begin
                     // Division by zero downstream: reject, keep old operands.
                     err <= 1'b1;
                  end
               end
            end

            RD: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= LAT;
               end
            end

            LAT: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  dp_w  <= w_rdata;
                  state <= WR;
               end
            end

            WR: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (idx == LAST_IDX) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= RD;
               end
            end

            DONE: begin
               // Abort has no effect here: the pass is already complete.
               pass_cnt <= pass_cnt + 16'd1;
               busy     <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bp_update_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bp_update_sequencer
//
// Directed bench for bp_update_sequencer with a 4-entry weight store and a
// behavioural update datapath:
//   dp_wn = dp_w + dp_bp * (1 - sign(-2*dp_w)) * dp_tm / dp_td
// where sign() is the two's-complement sign bit (1 for negative).
// -----------------------------------------------------------------------------
module tb_bp_update_sequencer;

   localparam int N  = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [31:0]   bp, tm, td;
   logic [AW-1:0] w_addr;
   logic [31:0]   w_rdata;
   logic          w_we;
   logic [31:0]   w_wdata;
   logic [31:0]   dp_w, dp_bp, dp_tm, dp_td;
   logic [31:0]   dp_wn;
   logic          busy, done, err;
   logic [15:0]   pass_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bp_update_sequencer #(.N_WEIGHTS(N), .ADDR_W(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .bp       (bp),
      .tm       (tm),
      .td       (td),
      .w_addr   (w_addr),
      .w_rdata  (w_rdata),
      .w_we     (w_we),
      .w_wdata  (w_wdata),
      .dp_w     (dp_w),
      .dp_bp    (dp_bp),
      .dp_tm    (dp_tm),
      .dp_td    (dp_td),
      .dp_wn    (dp_wn),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .pass_cnt (pass_cnt)
   );

   // Behavioural update datapath.
   always_comb begin
      logic signed [31:0] m2;
      logic signed [31:0] f;
      m2 = -32'sd2 * $signed(dp_w);
      f  = m2[31] ? 32'sd0 : 32'sd1;
      if (dp_td == '0)
         dp_wn = dp_w;
      else
         dp_wn = dp_w + (($signed(dp_bp) * f * $signed(dp_tm)) / $signed(dp_td));
   end

   // Weight store with registered read, write log and edge counter.
   logic [31:0] mem [N];
   logic [31:0] ld_vals [N];
   logic        ld_req = 1'b0;
   int          cyc = 0;
   int          wr_n = 0;
   int          wr_edge [64];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ld_req) begin
         for (int i = 0; i < N; i++) mem[i] <= ld_vals[i];
      end else if (w_we) begin
         mem[w_addr]       <= w_wdata;
         wr_edge[wr_n % 64] <= cyc + 1;
         wr_n              <= wr_n + 1;
      end
      w_rdata <= mem[w_addr];
   end

   // done monitor: the cycle index of a pulse is the last edge before it.
   int done_n  = 0;
   int done_at = -1;
   always @(negedge clk) begin
      if (done) begin
         done_n  <= done_n + 1;
         done_at <= cyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed time %0t required < 2000000", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic load_store(input int a, input int b, input int c, input int d);
      @(negedge clk);
      ld_vals[0] = a;
      ld_vals[1] = b;
      ld_vals[2] = c;
      ld_vals[3] = d;
      ld_req     = 1'b1;
      @(negedge clk);
      ld_req     = 1'b0;
   endtask

   // Returns the index of the edge at which start was sampled.
   task automatic start_pass(input int b, input int t, input int d, output int e);
      @(negedge clk);
      bp    = b;
      tm    = t;
      td    = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e     = cyc;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic check_store(input string tag, input int a, input int b, input int c, input int d);
      check({tag, "_w0"}, mem[0], a);
      check({tag, "_w1"}, mem[1], b);
      check({tag, "_w2"}, mem[2], c);
      check({tag, "_w3"}, mem[3], d);
   endtask

   initial begin
      int e, w0, d0;

      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      bp    = '0;
      tm    = '0;
      td    = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_done",     32'(done),     32'd0);
      check("rst_err",      32'(err),      32'd0);
      check("rst_w_we",     32'(w_we),     32'd0);
      check("rst_w_addr",   32'(w_addr),   32'd0);
      check("rst_w_wdata",  w_wdata,       32'd0);
      check("rst_dp_w",     dp_w,          32'd0);
      check("rst_dp_td",    dp_td,         32'd0);
      check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Nominal pass: {5,-5,0,7}, bp=3 tm=1 td=1 -> {5,-2,3,7}
      load_store(5, -5, 0, 7);
      w0 = wr_n;
      d0 = done_n;
      start_pass(3, 1, 1, e);
      check("p1_busy_rd", 32'(busy), 32'd1);
      wait_idle(100);
      check_store("p1", 5, -2, 3, 7);
      check("p1_nwr", wr_n - w0, 4);
      for (int i = 0; i < N; i++)
         check($sformatf("p1_wr_edge%0d", i), wr_edge[(w0 + i) % 64], e + 3 + 3 * i);
      check("p1_ndone",    done_n - d0,   1);
      check("p1_done_at",  done_at,       e + 12);
      check("p1_pass_cnt", 32'(pass_cnt), 32'd1);
      check("p1_dp_bp",    dp_bp,         32'd3);

      // Rejected start: td == 0
      w0 = wr_n;
      start_pass(5, 2, 0, e);
      check("z_err_hi",   32'(err),  32'd1);
      check("z_busy",     32'(busy), 32'd0);
      @(negedge clk);
      check("z_err_lo",   32'(err),  32'd0);
      check("z_busy2",    32'(busy), 32'd0);
      check("z_dp_td",    dp_td,     32'd1);
      check("z_dp_bp",    dp_bp,     32'd3);
      check("z_nwr",      wr_n - w0, 0);
      check("z_pass_cnt", 32'(pass_cnt), 32'd1);

      // Abort in the WR cycle of weight 1: {-5,-5,-5,-5}, bp=3 tm=4 td=2 (+6)
      load_store(-5, -5, -5, -5);
      w0 = wr_n;
      d0 = done_n;
      start_pass(3, 4, 2, e);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      #1;
      check("ab_w_we_forced", 32'(w_we), 32'd0);
      @(negedge clk);
      abort = 1'b0;
      check("ab_idle", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check_store("ab", 1, -5, -5, -5);
      check("ab_nwr",      wr_n - w0,     1);
      check("ab_ndone",    done_n - d0,   0);
      check("ab_pass_cnt", 32'(pass_cnt), 32'd1);

      // start held while busy is ignored: {-1,-2,0,4}, bp=1 -> {0,-1,1,4}
      load_store(-1, -2, 0, 4);
      d0 = done_n;
      start_pass(1, 1, 1, e);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_idle(100);
      repeat (3) @(negedge clk);
      check("sb_busy",     32'(busy),     32'd0);
      check("sb_ndone",    done_n - d0,   1);
      check("sb_pass_cnt", 32'(pass_cnt), 32'd2);
      check_store("sb", 0, -1, 1, 4);

      // Reset in LAT of weight 2: {-5 x4}, bp=3 tm=1 td=1 -> {-2,-2,-5,-5}
      load_store(-5, -5, -5, -5);
      w0 = wr_n;
      start_pass(3, 1, 1, e);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mr_busy",     32'(busy),     32'd0);
      check("mr_done",     32'(done),     32'd0);
      check("mr_err",      32'(err),      32'd0);
      check("mr_w_we",     32'(w_we),     32'd0);
      check("mr_w_addr",   32'(w_addr),   32'd0);
      check("mr_w_wdata",  w_wdata,       32'd0);
      check("mr_dp_w",     dp_w,          32'd0);
      check("mr_dp_bp",    dp_bp,         32'd0);
      check("mr_dp_tm",    dp_tm,         32'd0);
      check("mr_dp_td",    dp_td,         32'd0);
      check("mr_pass_cnt", 32'(pass_cnt), 32'd0);
      repeat (2) @(negedge clk);
      check("mr_nwr", wr_n - w0, 2);
      check_store("mr", -2, -2, -5, -5);
      rst = 1'b0;
      d0  = done_n;
      start_pass(3, 1, 1, e);
      wait_idle(100);
      check_store("mr_fresh", 1, 1, -2, -2);
      check("mr_fresh_ndone",    done_n - d0,   1);
      check("mr_fresh_pass_cnt", 32'(pass_cnt), 32'd1);

      // pass_cnt wrap
      @(negedge clk);
      force dut.pass_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.pass_cnt;
      @(negedge clk);
      check("wrap_preload", 32'(pass_cnt), 32'h0000_FFFF);
      start_pass(1, 1, 1, e);
      wait_idle(100);
      check("wrap_pass_cnt", 32'(pass_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
